// File: rtl/sar_search_pkg.sv
// rtl/sar_search_pkg.sv - shared state encoding and default width for the SAR search block
package sar_search_pkg;

  localparam int SAR_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } sar_state_t;

endpackage

// File: rtl/sar_search_4bit.sv
// rtl/sar_search_4bit.sv - successive-approximation search driving an external magnitude comparator
module sar_search_4bit
  import sar_search_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             e,
  input  logic             g,
  input  logic             l,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);
  localparam logic [IW-1:0]    TOP_IDX = IW'(WIDTH - 1);

  sar_state_t       r_state;
  sar_state_t       w_next;
  logic [WIDTH-1:0] r_probe;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_acc;
  logic [IW-1:0]    r_idx;
  logic             r_found;
  logic             r_err;

  // w_bit marks the bit currently under trial; w_acc_upd is acc after this compare's decision
  logic [WIDTH-1:0] w_bit;
  logic [WIDTH-1:0] w_acc_upd;
  logic             w_onehot;
  logic             w_last;

  assign w_bit     = ONE << r_idx;
  assign w_acc_upd = g ? (r_acc | w_bit) : (r_acc & ~w_bit);
  assign w_onehot  = ({e, g, l} == 3'b100) || ({e, g, l} == 3'b010) || ({e, g, l} == 3'b001);
  assign w_last    = (r_idx == '0);

  // State register; reset abandons any search in flight without a done pulse
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state: a compare ends on a bad code, an exact hit, or after the LSB decision
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_COMPARE;
      S_COMPARE: if (!w_onehot || e || w_last) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state: busy through the compare phase, done for the single DONE cycle
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_COMPARE: busy = 1'b1;
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
  end

  // Datapath: probe/acc/idx walk the bits MSB-first; result and flags are held outside a search
  always_ff @(posedge clk) begin
    if (rst) begin
      r_probe  <= '0;
      r_result <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_found  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_probe <= MSB;
            r_idx   <= TOP_IDX;
            r_acc   <= '0;
            r_found <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        S_COMPARE: begin
          if (!w_onehot) begin
            r_err    <= 1'b1;
            r_found  <= 1'b0;
            r_result <= '0;
          end else if (e) begin
            r_result <= r_probe;
            r_found  <= 1'b1;
          end else begin
            r_acc <= w_acc_upd;
            if (w_last) begin
              r_result <= w_acc_upd;
              r_found  <= 1'b0;
            end else begin
              r_probe <= w_acc_upd | (w_bit >> 1);
              r_idx   <= r_idx - IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign probe  = r_probe;
  assign result = r_result;
  assign found  = r_found;
  assign err    = r_err;

endmodule

// File: tb/tb_sar_search_4bit.sv
// tb/tb_sar_search_4bit.sv - directed scoreboard bench with a behavioral comparator closing the loop
module tb_sar_search_4bit;

  localparam int W = 4;

  typedef struct {
    int res;
    int fnd;
    int er;
    int lat;
  } outcome_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         e;
  logic         g;
  logic         l;
  logic [W-1:0] probe;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         found;
  logic         err;

  logic [W-1:0] target;
  logic         force_bad;

  int n_checks = 0;
  int n_errors = 0;
  int q_probe[$];
  outcome_t q_out[$];

  sar_search_4bit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .e      (e),
    .g      (g),
    .l      (l),
    .probe  (probe),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Behavioral magnitude comparator, optionally overridden with an illegal e=g=1 code
  always_comb begin
    if (force_bad) begin
      e = 1'b1; g = 1'b1; l = 1'b0;
    end else begin
      e = (target == probe);
      g = (target > probe);
      l = (target < probe);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model of a halving binary search: pushes expected probes and outcome to the scoreboard
  task automatic model_search(input int tgt, input int bad_at);
    int p, step, k;
    outcome_t o;
    p = 1 << (W - 1);
    step = p / 2;
    k = 1;
    forever begin
      q_probe.push_back(p);
      if (bad_at == k) begin
        o.res = 0; o.fnd = 0; o.er = 1; o.lat = k + 1;
        break;
      end
      if (tgt == p) begin
        o.res = p; o.fnd = 1; o.er = 0; o.lat = k + 1;
        break;
      end
      if (step == 0) begin
        o.res = (tgt > p) ? p : p - 1; o.fnd = 0; o.er = 0; o.lat = k + 1;
        break;
      end
      p = (tgt > p) ? p + step : p - step;
      step = step / 2;
      k++;
    end
    q_out.push_back(o);
  endtask

  // Runs one search from the current negedge; returns at the negedge of the done cycle
  task automatic run_search(input int tgt, input int bad_at, input bit hold, input bit poke,
                            output int n_wait);
    int cyc;
    outcome_t o;
    model_search(tgt, bad_at);
    target = W'(tgt);
    start  = 1'b1;
    n_wait = 0;
    while ((busy || done) && n_wait < 10) begin
      @(negedge clk);
      n_wait++;
    end
    @(negedge clk);
    start = poke;
    cyc = 1;
    while (!done && cyc <= 10) begin
      check("busy_in_compare", int'(busy), 1);
      if (q_probe.size() > 0) check("probe", int'(probe), q_probe.pop_front());
      else                    check("probe_extra_compare", int'(probe), -1);
      force_bad = (bad_at == cyc);
      @(negedge clk);
      cyc++;
    end
    force_bad = 1'b0;
    start = hold;
    check("done_seen", int'(done), 1);
    if (q_out.size() > 0) begin
      o = q_out.pop_front();
      check("latency", cyc, o.lat);
      check("result", int'(result), o.res);
      check("found", int'(found), o.fnd);
      check("err", int'(err), o.er);
      check("busy_in_done", int'(busy), 0);
    end
    q_probe.delete();
  endtask

  initial begin
    int nw;
    rst = 1'b1; start = 1'b0; target = '0; force_bad = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_probe", int'(probe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_found", int'(found), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Early exit on equality, then outputs hold through idle
    run_search(10, 0, 1'b0, 1'b0, nw);
    @(negedge clk);
    @(negedge clk);
    check("idle_hold_result", int'(result), 10);
    check("idle_hold_found", int'(found), 1);
    check("idle_hold_probe", int'(probe), 10);
    check("idle_busy", int'(busy), 0);

    // Full-length searches at both ends of the range
    run_search(0, 0, 1'b0, 1'b0, nw);
    @(negedge clk);
    run_search(15, 0, 1'b0, 1'b0, nw);
    @(negedge clk);

    // Illegal comparator code on the second compare
    run_search(10, 2, 1'b0, 1'b0, nw);
    @(negedge clk);

    // Reset during the third compare aborts without a done pulse
    target = 4'd15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_probe1", int'(probe), 8);
    @(negedge clk);
    check("abort_probe2", int'(probe), 12);
    @(negedge clk);
    check("abort_probe3", int'(probe), 14);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_probe", int'(probe), 0);
    check("abort_result", int'(result), 0);
    @(negedge clk);
    check("abort_no_done", int'(done), 0);
    run_search(6, 0, 1'b0, 1'b0, nw);
    @(negedge clk);

    // start pulsed during the compare phase must not queue another search
    run_search(9, 0, 1'b0, 1'b1, nw);
    @(negedge clk);
    check("no_queue_busy1", int'(busy), 0);
    @(negedge clk);
    check("no_queue_busy2", int'(busy), 0);

    // start held high: back-to-back searches, one per idle visit
    run_search(5, 0, 1'b1, 1'b1, nw);
    run_search(5, 0, 1'b1, 1'b1, nw);
    check("b2b_idle_gap", nw, 1);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_stop", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sar_search_4bit.md
SAR_SEARCH_4BIT -- requirements
Module: sar_search_4bit

Interface
REQ-001 Parameter WIDTH, default 4, is the probe/result width in bits; search length is WIDTH compare cycles.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 e  input  1  external comparator "target == probe".
REQ-006 g  input  1  external comparator "target > probe".
REQ-007 l  input  1  external comparator "target < probe".
REQ-008 probe  output  WIDTH  registered trial value driven to the external comparator's b side.
REQ-009 busy  output  1  high while in COMPARE.
REQ-010 done  output  1  one-cycle pulse; result/found/err valid in the same cycle.
REQ-011 result  output  WIDTH  search result, held until the next accepted start.
REQ-012 found  output  1  high if e was seen during the last search.
REQ-013 err  output  1  high if the last search aborted on an illegal e/g/l code.

Function
REQ-014 The FSM SHALL have states IDLE, COMPARE and DONE.
REQ-015 In IDLE with start=1, the block SHALL load probe=1<<(WIDTH-1), idx=WIDTH-1, acc=0, clear found/err, and enter COMPARE; busy SHALL go high next cycle.
REQ-016 In IDLE with start=0, the block SHALL hold all outputs.
REQ-017 The comparator is combinational on registered probe; each COMPARE cycle SHALL sample e/g/l against the current probe.
REQ-018 e=1 (g=l=0): result<=probe, found<=1, enter DONE.
REQ-019 g=1 (e=l=0): bit idx of acc SHALL be kept set.
REQ-020 l=1 (e=g=0): bit idx of acc SHALL be cleared.
REQ-021 After the g or l update at idx>0: probe<=acc|(1<<(idx-1)), idx<=idx-1, stay in COMPARE.
REQ-022 After the g or l update at idx=0: result<=updated acc, found<=0, enter DONE.
REQ-023 Any e/g/l code that is not one-hot SHALL set err=1, found=0 and result=0, and enter DONE.
REQ-024 DONE SHALL last exactly one cycle with done=1 and busy=0, then go to IDLE.
REQ-025 Latency from the start-accept edge to done SHALL be at most WIDTH+1 cycles; early exit on e SHALL shorten it.
REQ-026 start asserted while busy or in DONE SHALL be ignored; no queuing.
REQ-027 start held high continuously SHALL launch back-to-back searches, one per IDLE visit.
REQ-028 probe SHALL keep its last value outside COMPARE.

Reset
REQ-029 With rst=1 at a clock edge: state=IDLE, probe=0, result=0, idx=0, acc=0, busy=0, done=0, found=0, err=0.
REQ-030 Reset SHALL take priority over start and comparator inputs, and SHALL abort a search mid-COMPARE without a done pulse.

Structure
REQ-031 A shared package sar_search_pkg SHALL hold the state enumeration and the default WIDTH constant.
REQ-032 The block SHALL be a single module with no sub-module; the bench closes the loop with a behavioral WIDTH-bit magnitude comparator model.

Verification
REQ-033 Target=10, start pulse -> probes 8,12,10 then e -> done on the third compare, result=10, found=1.
REQ-034 Target=0 -> probes 8,4,2,1, all l -> done after 4 compares, result=0, found=0.
REQ-035 Target=15 -> probes 8,12,14,15, e on the last -> result=15, found=1, latency WIDTH+1.
REQ-036 Force e=g=1 on the second compare -> done with err=1, found=0, result=0.
REQ-037 Assert rst during the third compare -> next cycle IDLE, all outputs zero, no done; a new start then completes normally.
REQ-038 Pulse start while busy -> ignored; start held high with target=5 -> two consecutive searches, each result=5.
